// File: rtl/pdm_word_packer.sv
// Packs MICS-wide PDM sample sets into BITS-wide words on a valid/ready source port.
// Optional drop counter output enabled by defining PDM_PACKER_DROP_COUNT_EN.
module pdm_word_packer #(
  parameter int MICS = 8,
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture_en,
  input  logic            sample_en,
  input  logic [MICS-1:0] pdm_bits,
  output logic            send_tvalid,
  input  logic            send_tready,
  output logic [BITS-1:0] send_tdata,
  output logic            overflow,
  input  logic            overflow_clr
`ifdef PDM_PACKER_DROP_COUNT_EN
  ,
  output logic [15:0]     drop_count
`endif
);

  localparam int K  = BITS / MICS;
  localparam int FW = (K > 2) ? $clog2(K) : 1;

  if ((BITS % MICS) != 0 || (BITS / MICS) < 2) begin : g_bad_cfg
    $error("pdm_word_packer: BITS must be a multiple of MICS with BITS/MICS >= 2");
  end

  logic [BITS-1:0] shreg;
  logic [FW-1:0]   fill;
  logic [BITS-1:0] next_word;
  logic            strobe;
  logic            last;
  logic            complete;
  logic            xfer;
  logic            drop;

  // The newest sample set enters at the top, so the first set of a word ends in the LSBs.
  assign next_word = {pdm_bits, shreg[BITS-1:MICS]};
  assign strobe    = sample_en && capture_en;
  assign last      = (fill == FW'(K - 1));
  assign complete  = strobe && last;
  assign xfer      = send_tvalid && send_tready;
  assign drop      = complete && send_tvalid && !send_tready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg       <= '0;
      fill        <= '0;
      send_tvalid <= 1'b0;
      send_tdata  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (!capture_en) begin
        shreg <= '0;
        fill  <= '0;
      end else if (sample_en) begin
        shreg <= next_word;
        fill  <= last ? '0 : fill + FW'(1);
      end

      // A completing word may replace one leaving in the same cycle; otherwise it is dropped.
      if (complete && (!send_tvalid || send_tready)) begin
        send_tdata  <= next_word;
        send_tvalid <= 1'b1;
      end else if (xfer) begin
        send_tvalid <= 1'b0;
      end

      if (drop)
        overflow <= 1'b1;
      else if (overflow_clr)
        overflow <= 1'b0;
    end
  end

`ifdef PDM_PACKER_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst)
      drop_count <= '0;
    else if (overflow_clr)
      drop_count <= drop ? 16'd1 : 16'd0;
    else if (drop && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pdm_word_packer.sv
// Scoreboard bench for pdm_word_packer (MICS=8, BITS=32); expected words are queued
// as stimulus is driven and checked on every output handshake.
module tb_pdm_word_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_en;
  logic        sample_en;
  logic [7:0]  pdm_bits;
  logic        send_tvalid;
  logic        send_tready;
  logic [31:0] send_tdata;
  logic        overflow;
  logic        overflow_clr;
`ifdef PDM_PACKER_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb[$];

  pdm_word_packer #(.MICS(8), .BITS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .capture_en   (capture_en),
    .sample_en    (sample_en),
    .pdm_bits     (pdm_bits),
    .send_tvalid  (send_tvalid),
    .send_tready  (send_tready),
    .send_tdata   (send_tdata),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef PDM_PACKER_DROP_COUNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Handshake monitor: sampled mid-cycle, the transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (rst && send_tvalid && send_tready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_word", send_tdata, 32'hxxxxxxxx);
      end else begin
        check("sb_word", send_tdata, sb.pop_front());
      end
    end
  end

  task automatic strobe(input logic [7:0] b);
    sample_en = 1'b1;
    pdm_bits  = b;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst          = 1'b0;
    capture_en   = 1'b1;
    sample_en    = 1'b0;
    pdm_bits     = 8'h00;
    send_tready  = 1'b1;
    overflow_clr = 1'b0;

    // Reset with strobes pulsing
    strobe(8'hF0);
    strobe(8'hF1);
    check("rst_tvalid", {31'd0, send_tvalid}, 32'd0);
    check("rst_tdata", send_tdata, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b1;

    // Packing order
    sb.push_back(32'h44332211);
    strobe(8'h11); strobe(8'h22); strobe(8'h33);
    check("pack_tvalid_early", {31'd0, send_tvalid}, 32'd0);
    strobe(8'h44);
    check("pack_tvalid", {31'd0, send_tvalid}, 32'd1);
    check("pack_tdata", send_tdata, 32'h44332211);
    idle(1);
    check("pack_tvalid_fall", {31'd0, send_tvalid}, 32'd0);

    // Stall hold with drop
    send_tready = 1'b0;
    sb.push_back(32'h44332211);
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
    strobe(8'h55); strobe(8'h66); strobe(8'h77); strobe(8'h88);
    check("stall_tvalid", {31'd0, send_tvalid}, 32'd1);
    check("stall_tdata", send_tdata, 32'h44332211);
    check("stall_overflow", {31'd0, overflow}, 32'd1);
`ifdef PDM_PACKER_DROP_COUNT_EN
    check("stall_drop_count", {16'd0, drop_count}, 32'd1);
`endif
    send_tready = 1'b1;
    idle(1);
    check("stall_tvalid_fall", {31'd0, send_tvalid}, 32'd0);
    check("stall_tdata_hold", send_tdata, 32'h44332211);
    overflow_clr = 1'b1;
    idle(1);
    overflow_clr = 1'b0;
    check("clr_overflow", {31'd0, overflow}, 32'd0);

    // Back-to-back strobes every cycle
    sb.push_back(32'h04030201);
    sb.push_back(32'h08070605);
    sb.push_back(32'h0C0B0A09);
    for (int i = 1; i <= 12; i++) strobe(8'(i));
    check("b2b_tdata", send_tdata, 32'h0C0B0A09);
    idle(1);
    check("b2b_overflow", {31'd0, overflow}, 32'd0);

    // Transfer coinciding with a completion
    send_tready = 1'b0;
    sb.push_back(32'h24232221);
    sb.push_back(32'h28272625);
    strobe(8'h21); strobe(8'h22); strobe(8'h23); strobe(8'h24);
    strobe(8'h25); strobe(8'h26); strobe(8'h27);
    send_tready = 1'b1;
    strobe(8'h28);
    check("coin_tvalid", {31'd0, send_tvalid}, 32'd1);
    check("coin_tdata", send_tdata, 32'h28272625);
    check("coin_overflow", {31'd0, overflow}, 32'd0);
    idle(1);
    check("coin_tvalid_fall", {31'd0, send_tvalid}, 32'd0);

    // capture_en abort of a partial word
    sb.push_back(32'hDDCCBBAA);
    strobe(8'hE1); strobe(8'hE2);
    capture_en = 1'b0;
    strobe(8'hE3);
    capture_en = 1'b1;
    strobe(8'hAA); strobe(8'hBB); strobe(8'hCC);
    check("abort_no_word", {31'd0, send_tvalid}, 32'd0);
    strobe(8'hDD);
    check("abort_tdata", send_tdata, 32'hDDCCBBAA);
    check("abort_overflow", {31'd0, overflow}, 32'd0);
    idle(1);

    // Held word survives capture_en going low
    send_tready = 1'b0;
    sb.push_back(32'h34333231);
    strobe(8'h31); strobe(8'h32); strobe(8'h33); strobe(8'h34);
    capture_en = 1'b0;
    idle(2);
    check("held_tvalid", {31'd0, send_tvalid}, 32'd1);
    send_tready = 1'b1;
    idle(1);
    capture_en = 1'b1;
    check("held_tvalid_fall", {31'd0, send_tvalid}, 32'd0);

    // Overflow clear and drop counting
    send_tready = 1'b0;
    sb.push_back(32'h44434241);
    strobe(8'h41); strobe(8'h42); strobe(8'h43); strobe(8'h44);
    for (int i = 0; i < 12; i++) strobe(8'(8'h50 + i));
    check("ovf3_overflow", {31'd0, overflow}, 32'd1);
    check("ovf3_tdata", send_tdata, 32'h44434241);
`ifdef PDM_PACKER_DROP_COUNT_EN
    check("ovf3_drop_count", {16'd0, drop_count}, 32'd3);
`endif
    overflow_clr = 1'b1;
    idle(1);
    overflow_clr = 1'b0;
    check("clr_alone_overflow", {31'd0, overflow}, 32'd0);
`ifdef PDM_PACKER_DROP_COUNT_EN
    check("clr_alone_count", {16'd0, drop_count}, 32'd0);
`endif
    strobe(8'h61); strobe(8'h62); strobe(8'h63);
    overflow_clr = 1'b1;
    strobe(8'h64);
    overflow_clr = 1'b0;
    check("clr_drop_overflow", {31'd0, overflow}, 32'd1);
`ifdef PDM_PACKER_DROP_COUNT_EN
    check("clr_drop_count", {16'd0, drop_count}, 32'd1);
`endif
    send_tready = 1'b1;
    idle(1);
    check("final_tvalid", {31'd0, send_tvalid}, 32'd0);
    idle(2);
    check("sb_leftover", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
